// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the cpu controller
// Holds the FSM state enum, instruction class enum, opcode/op field values,
// and the nsel/vsel/mem_cmd encodings used by cpu_controller and instr_decode.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM,
        S_GETA, S_GETB, S_EXEC, S_WREG,
        S_ADDR, S_LADDR, S_MEMRD, S_WMEM,
        S_GETD, S_PASS, S_MEMWR, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_MOVI, C_MOVR, C_ALU, C_CMP, C_MVN, C_LDR, C_STR, C_HALT, C_ILL
    } iclass_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] NSEL_RN = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RM = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_MDATA = 2'b10;
    localparam logic [1:0] VSEL_IMM   = 2'b11;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction classifier
// Ports: opcode (ir[15:13]), op (ir[12:11]) in; cls (instruction class) and
// illegal (undefined opcode/op combination) out.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output iclass_t    cls,
    output logic       illegal
);

    always_comb begin
        cls = C_ILL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOVI)      cls = C_MOVI;
                else if (op == OP_MOVR) cls = C_MOVR;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD, OP_AND: cls = C_ALU;
                    OP_CMP:         cls = C_CMP;
                    default:        cls = C_MVN;
                endcase
            end
            OPC_LDR:  cls = C_LDR;
            OPC_STR:  cls = C_STR;
            OPC_HALT: cls = C_HALT;
            default:  cls = C_ILL;
        endcase
        illegal = (cls == C_ILL);
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore FSM sequencing fetch, decode and execute
// Ports: clk, reset (async active-high), ir (instruction), mem_ready in;
// datapath strobes/selects (nsel, vsel, loada..write, ALUop, shift), fetch
// strobes (load_ir, load_pc, reset_pc, load_addr, addr_sel), mem_cmd, and
// halted/illegal status out.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        mem_ready,
    output logic [1:0]  nsel,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halted,
    output logic        illegal
);

    state_t  state_q, state_d;
    iclass_t cls_q, cls_d;
    logic    illegal_q, illegal_d;
    iclass_t dec_cls;
    logic    dec_illegal;

    // Register-field bits are consumed by the datapath mux, not here.
    logic unused_ir;
    assign unused_ir = ^{ir[10:5], ir[2:0]};

    instr_decode u_decode (
        .opcode  (ir[15:13]),
        .op      (ir[12:11]),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RST;
            cls_q     <= C_ILL;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
        end
    end

    // Class is captured in S_DEC so later dispatch ignores ir changes.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  if (mem_ready) state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                cls_d     = dec_cls;
                illegal_d = dec_illegal;
                case (dec_cls)
                    C_MOVI:                 state_d = S_WIMM;
                    C_MOVR, C_MVN:          state_d = S_GETB;
                    C_ALU, C_CMP:           state_d = S_GETA;
                    C_LDR, C_STR:           state_d = S_GETA;
                    default:                state_d = S_HALT;
                endcase
            end
            S_WIMM: state_d = S_IF1;
            S_GETA: state_d = (cls_q == C_LDR || cls_q == C_STR) ? S_ADDR : S_GETB;
            S_GETB: state_d = S_EXEC;
            S_EXEC: state_d = (cls_q == C_CMP) ? S_IF1 : S_WREG;
            S_WREG: state_d = S_IF1;
            S_ADDR: state_d = S_LADDR;
            S_LADDR: state_d = (cls_q == C_LDR) ? S_MEMRD : S_GETD;
            S_MEMRD: if (mem_ready) state_d = S_WMEM;
            S_WMEM: state_d = S_IF1;
            S_GETD: state_d = S_PASS;
            S_PASS: state_d = S_MEMWR;
            S_MEMWR: if (mem_ready) state_d = S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        nsel      = NSEL_RN;
        vsel      = VSEL_C;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        write     = 1'b0;
        ALUop     = 2'b00;
        shift     = 2'b00;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
            end
            S_UPC:  load_pc = 1'b1;
            S_WIMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_GETA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                shift = ir[4:3];
                if (cls_q == C_MOVR) begin
                    asel  = 1'b1;
                    loadc = 1'b1;
                end else if (cls_q == C_CMP) begin
                    ALUop = ir[12:11];
                    loads = 1'b1;
                end else begin
                    ALUop = ir[12:11];
                    loadc = 1'b1;
                end
            end
            S_WREG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LADDR: load_addr = 1'b1;
            S_MEMRD: mem_cmd = MEM_READ;
            S_WMEM: begin
                mem_cmd = MEM_READ;
                vsel    = VSEL_MDATA;
                nsel    = NSEL_RD;
                write   = 1'b1;
            end
            S_GETD: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_PASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEMWR: mem_cmd = MEM_WRITE;
            S_HALT: begin
                halted  = 1'b1;
                illegal = illegal_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        mem_ready = 1'b1;
    logic [1:0]  nsel, vsel, ALUop, shift, mem_cmd;
    logic        loada, loadb, loadc, loads, asel, bsel, write;
    logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, halted, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .write(write), .ALUop(ALUop), .shift(shift), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
        .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted),
        .illegal(illegal)
    );

    typedef struct {
        string       tag;
        logic [23:0] exp;
        logic [15:0] ir;
        logic        rdy;
    } entry_t;

    entry_t sb[$];

    logic [23:0] obs;
    assign obs = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                  ALUop, shift, load_ir, load_pc, reset_pc, load_addr, addr_sel,
                  mem_cmd, halted, illegal};

    function automatic logic [23:0] ov(
        input logic [1:0] f_nsel, input logic [1:0] f_vsel,
        input logic la, input logic lb, input logic lc, input logic ls,
        input logic as, input logic bs, input logic wr,
        input logic [1:0] alu, input logic [1:0] sh,
        input logic lir, input logic lpc, input logic rpc, input logic ladr,
        input logic asl, input logic [1:0] mc, input logic h, input logic il);
        return {f_nsel, f_vsel, la, lb, lc, ls, as, bs, wr, alu, sh,
                lir, lpc, rpc, ladr, asl, mc, h, il};
    endfunction

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input string tag, input logic [23:0] exp, input logic [15:0] i, input logic r);
        entry_t e;
        e.tag = tag; e.exp = exp; e.ir = i; e.rdy = r;
        sb.push_back(e);
    endtask

    logic [23:0] v_rst, v_if1, v_if2, v_upc, v_dec, v_wimm, v_geta, v_getb, v_wreg;
    logic [23:0] v_addr, v_laddr, v_memrd, v_wmem, v_getd, v_pass, v_memwr, v_halt, v_ill;

    task automatic push_fetch(input logic [15:0] i, input int if2_waits);
        push("if1", v_if1, i, 1'b1);
        for (int k = 0; k < if2_waits; k++) push("if2_wait", v_if2, i, 1'b0);
        push("if2", v_if2, i, 1'b1);
        push("upc", v_upc, i, 1'b1);
        push("dec", v_dec, i, 1'b1);
    endtask

    // Starts on a negedge; each entry is checked at a negedge, then its
    // mem_ready value is applied for the following rising edge.
    task automatic run_queue();
        entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ir = e.ir;
            #1;
            check_eq(e.tag, obs, e.exp);
            check_eq({e.tag, "_wr_excl"}, {23'b0, write & (mem_cmd == 2'b10)}, 24'h0);
            mem_ready = e.rdy;
            @(negedge clk);
        end
    endtask

    initial begin
        v_rst   = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,1,1,0,0, 0, 0,0);
        v_if1   = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,0,1, 1, 0,0);
        v_if2   = ov(0,0, 0,0,0,0,0,0,0, 0,0, 1,0,0,0,1, 1, 0,0);
        v_upc   = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,1,0,0,0, 0, 0,0);
        v_dec   = 24'h0;
        v_wimm  = ov(0,3, 0,0,0,0,0,0,1, 0,0, 0,0,0,0,0, 0, 0,0);
        v_geta  = ov(0,0, 1,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0, 0,0);
        v_getb  = ov(2,0, 0,1,0,0,0,0,0, 0,0, 0,0,0,0,0, 0, 0,0);
        v_wreg  = ov(1,0, 0,0,0,0,0,0,1, 0,0, 0,0,0,0,0, 0, 0,0);
        v_addr  = ov(0,0, 0,0,1,0,0,1,0, 0,0, 0,0,0,0,0, 0, 0,0);
        v_laddr = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,1,0, 0, 0,0);
        v_memrd = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 1, 0,0);
        v_wmem  = ov(1,2, 0,0,0,0,0,0,1, 0,0, 0,0,0,0,0, 1, 0,0);
        v_getd  = ov(1,0, 0,1,0,0,0,0,0, 0,0, 0,0,0,0,0, 0, 0,0);
        v_pass  = ov(0,0, 0,0,1,0,1,0,0, 0,0, 0,0,0,0,0, 0, 0,0);
        v_memwr = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 2, 0,0);
        v_halt  = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0, 1,0);
        v_ill   = ov(0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0, 1,1);

        // Held in reset: RST outputs, not halted.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_held", obs, v_rst);
        reset = 1'b0;

        push("rst_rel", v_rst, 16'hD105, 1'b1);
        push_fetch(16'hD105, 0);
        push("wimm", v_wimm, 16'hD105, 1'b1);

        push_fetch(16'hA0A1, 0);
        push("add_geta", v_geta, 16'hA0A1, 1'b1);
        push("add_getb", v_getb, 16'hA0A1, 1'b1);
        push("add_exec", ov(0,0, 0,0,1,0,0,0,0, 0,0, 0,0,0,0,0, 0, 0,0), 16'hA0A1, 1'b1);
        push("add_wreg", v_wreg, 16'hA0A1, 1'b1);

        push_fetch(16'hA9E0, 0);
        push("cmp_geta", v_geta, 16'hA9E0, 1'b1);
        push("cmp_getb", v_getb, 16'hA9E0, 1'b1);
        push("cmp_exec", ov(0,0, 0,0,0,1,0,0,0, 1,0, 0,0,0,0,0, 0, 0,0), 16'hA9E0, 1'b1);

        push_fetch(16'hC018, 0);
        push("movr_getb", v_getb, 16'hC018, 1'b1);
        push("movr_exec", ov(0,0, 0,0,1,0,1,0,0, 0,3, 0,0,0,0,0, 0, 0,0), 16'hC018, 1'b1);
        push("movr_wreg", v_wreg, 16'hC018, 1'b1);

        push_fetch(16'hB808, 0);
        push("mvn_getb", v_getb, 16'hB808, 1'b1);
        push("mvn_exec", ov(0,0, 0,0,1,0,0,0,0, 3,1, 0,0,0,0,0, 0, 0,0), 16'hB808, 1'b1);
        push("mvn_wreg", v_wreg, 16'hB808, 1'b1);

        push_fetch(16'h6120, 0);
        push("ldr_geta", v_geta, 16'h6120, 1'b1);
        push("ldr_addr", v_addr, 16'h6120, 1'b1);
        push("ldr_laddr", v_laddr, 16'h6120, 1'b0);
        for (int k = 0; k < 3; k++) push("ldr_memrd_wait", v_memrd, 16'h6120, 1'b0);
        push("ldr_memrd", v_memrd, 16'h6120, 1'b1);
        push("ldr_wmem", v_wmem, 16'h6120, 1'b1);

        push_fetch(16'h8120, 1);
        push("str_geta", v_geta, 16'h8120, 1'b1);
        push("str_addr", v_addr, 16'h8120, 1'b1);
        push("str_laddr", v_laddr, 16'h8120, 1'b1);
        push("str_getd", v_getd, 16'h8120, 1'b1);
        push("str_pass", v_pass, 16'h8120, 1'b0);
        push("str_memwr", v_memwr, 16'h8120, 1'b0);
        run_queue();

        // Still in S_MEMWR; reset must drop mem_cmd without a clock edge.
        check_eq("memwr_before_rst", {22'b0, mem_cmd}, 24'h2);
        reset = 1'b1;
        #1;
        check_eq("rst_async", obs, v_rst);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        push("rst_after_memwr", v_rst, 16'hE000, 1'b1);
        push_fetch(16'hE000, 0);
        for (int k = 0; k < 20; k++) push("halt", v_halt, 16'hE000, 1'b1);
        run_queue();

        reset = 1'b1;
        #1;
        check_eq("rst_from_halt", obs, v_rst);
        @(negedge clk);
        reset = 1'b0;
        push("rst_rel2", v_rst, 16'h0000, 1'b1);
        push_fetch(16'h0000, 0);
        for (int k = 0; k < 3; k++) push("illegal", v_ill, 16'h0000, 1'b1);
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces state S_RST immediately.
REQ-003 ir  input  16  current instruction register contents: opcode[15:13], op[12:11], shift[4:3].
REQ-004 mem_ready  input  1  memory has valid read data / accepted write this cycle.
REQ-005 nsel  output  2  register-field select to the register-number mux: 00 Rn, 01 Rd, 10 Rm.
REQ-006 vsel  output  2  write-back source: 00 C, 01 PC, 10 mdata, 11 sximm8.
REQ-007 loada, loadb, loadc, loads, asel, bsel, write  output  1 each  datapath strobes/selects.
REQ-008 ALUop  output  2  ALU operation; shift  output  2  shifter control.
REQ-009 load_ir, load_pc, reset_pc, load_addr, addr_sel  output  1 each  fetch/address strobes; addr_sel=1 selects PC.
REQ-010 mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE.
REQ-011 halted  output  1  high in S_HALT; illegal  output  1  high when halted by an undefined opcode.

Function
REQ-012 Outputs SHALL be Moore, decoded from current state plus ir fields only; unlisted outputs are 0 in every state.
REQ-013 S_RST: reset_pc=1, load_pc=1 for one cycle, then S_IF1.
REQ-014 S_IF1: addr_sel=1, mem_cmd=READ -> S_IF2; S_IF2: same plus load_ir=1, holds until mem_ready=1, then S_UPC.
REQ-015 S_UPC: load_pc=1 -> S_DEC; S_DEC dispatches on opcode/op, no strobes.
REQ-016 MOV imm (110/10): S_WIMM nsel=Rn, vsel=11, write=1 -> S_IF1 (fetch-to-fetch 5 cycles at zero wait).
REQ-017 MOV reg (110/00): S_GETB (nsel=Rm, loadb) -> S_EXEC (asel=1, bsel=0, ALUop=00, shift=ir, loadc) -> S_WREG (nsel=Rd, vsel=00, write) -> S_IF1.
REQ-018 ADD/AND (101/00,10): S_GETA (nsel=Rn, loada) -> S_GETB -> S_EXEC (asel=0, ALUop=ir op, loadc) -> S_WREG.
REQ-019 CMP (101/01): S_GETA -> S_GETB -> S_EXEC with loads=1, loadc=0 -> S_IF1; status register is written only by CMP.
REQ-020 MVN (101/11): S_GETB -> S_EXEC (ALUop=11, loadc) -> S_WREG; S_GETA skipped.
REQ-021 LDR (011): S_GETA -> S_ADDR (asel=0, bsel=1, ALUop=00, shift=00, loadc) -> S_LADDR (load_addr) -> S_MEMRD (addr_sel=0, mem_cmd=READ, holds until mem_ready) -> S_WMEM (mem_cmd=READ, vsel=10, nsel=Rd, write) -> S_IF1.
REQ-022 STR (100): S_GETA -> S_ADDR -> S_LADDR -> S_GETD (nsel=Rd, loadb) -> S_PASS (asel=1, bsel=0, shift=00, loadc) -> S_MEMWR (addr_sel=0, mem_cmd=WRITE, holds until mem_ready) -> S_IF1.
REQ-023 HALT (111) -> S_HALT; any other opcode/op combination -> S_HALT with illegal=1; S_HALT exits only on reset.
REQ-024 ALUop and shift SHALL be forced to 00 in every state outside S_EXEC.
REQ-025 write and mem_cmd=WRITE SHALL never be asserted in the same cycle.
REQ-026 ir changing while not in S_DEC..S_WREG has no effect until next S_DEC; load_ir occurs only in S_IF2.

Reset
REQ-027 Reset SHALL take effect asynchronously in any state, including mid-S_MEMRD/S_MEMWR, dropping mem_cmd and write to 0 before next edge.
REQ-028 While reset is high: state=S_RST, halted=0, illegal=0; on release S_RST outputs apply for exactly one cycle.

Structure
REQ-029 Package cpu_pkg SHALL hold the state enum, opcode/op constants, mem_cmd and nsel encodings.
REQ-030 One combinational sub-module instr_decode SHALL classify ir into instruction class and illegal flag.

Verification
REQ-031 Reset then ir=16'hD105 (MOV R1,#5), mem_ready=1 -> IF1,IF2,UPC,DEC,WIMM with nsel=00, vsel=11, write=1, back to IF1.
REQ-032 ir=16'hA0A1 (ADD) -> GETA,GETB,EXEC,WREG; ALUop=00 only in EXEC; write=1 only in WREG with vsel=00.
REQ-033 ir=16'hA9E0 (CMP) -> loads=1 in EXEC, loadc=0, write never asserted.
REQ-034 LDR with mem_ready low 3 cycles in S_MEMRD -> state held 3 extra cycles, write pulses once in S_WMEM.
REQ-035 Assert reset mid-S_MEMWR -> mem_cmd=00 immediately; after release reset_pc=1 one cycle.
REQ-036 ir=16'hE000 -> halted=1, illegal=0, held 20 cycles; ir=16'h0000 -> halted=1, illegal=1.
